// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and encodings, also consumed by the decode stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR_C = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// IF-stage bus: ROM read port, EX redirect/decode stall inputs and the IF/ID outputs.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] INSTRUCTION_ADDRESS;
    logic [31:0]       INSTRUCTION;
    logic              STALL;
    logic              BRANCH_TAKEN;
    logic [31:0]       BRANCH_TARGET;
    logic [31:0]       PC_OUT;
    logic [31:0]       INSTR_OUT;
    logic              VALID_OUT;
    logic              HALTED;
    logic              FETCH_FAULT;
    logic [31:0]       FETCH_COUNT;

    modport master (
        output INSTRUCTION_ADDRESS, PC_OUT, INSTR_OUT, VALID_OUT,
               HALTED, FETCH_FAULT, FETCH_COUNT,
        input  INSTRUCTION, STALL, BRANCH_TAKEN, BRANCH_TARGET
    );

    modport slave (
        input  INSTRUCTION_ADDRESS, PC_OUT, INSTR_OUT, VALID_OUT,
               HALTED, FETCH_FAULT, FETCH_COUNT,
        output INSTRUCTION, STALL, BRANCH_TAKEN, BRANCH_TARGET
    );
endinterface

// File: rtl/instr_fetch_unit_pc_gen.sv
// PC register with +4 incrementer, redirect mux and alignment/range checks.
module pc_gen #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [31:0]       target,
    input  logic              inc,
    output logic [31:0]       pc,
    output logic [ADDR_W-1:0] word_addr,
    output logic              target_misaligned,
    output logic              pc_out_of_range
);

    // A misaligned target is still loaded, rounded down, so the frozen PC stays word-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {target[31:2], 2'b00};
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

    assign word_addr         = pc[ADDR_W+1:2];
    assign target_misaligned = (target[1:0] != 2'b00);
    assign pc_out_of_range   = |pc[31:ADDR_W+2];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: fetch FSM, IF/ID boundary register and delivered-instruction counter.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C,
    parameter logic [31:0] EBREAK_INSTR = EBREAK_INSTR_C
) (
    input  logic                CLK,
    input  logic                RST_N,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t      state_q, state_d;
    ifid_t             ifid_p1, ifid_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;
    logic              pc_load, pc_inc;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] word_addr;
    logic              target_misaligned;
    logic              pc_out_of_range;

    pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk               (CLK),
        .rst_n             (RST_N),
        .load              (pc_load),
        .target            (bus.BRANCH_TARGET),
        .inc               (pc_inc),
        .pc                (pc),
        .word_addr         (word_addr),
        .target_misaligned (target_misaligned),
        .pc_out_of_range   (pc_out_of_range)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_BOOT;
            ifid_p1 <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ifid_p1 <= ifid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_p1;
        fault_d = fault_q;
        count_d = count_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            ST_BOOT, ST_RUN: begin
                if (state_q == ST_BOOT) begin
                    state_d = ST_RUN;
                end
                // Redirect outranks everything, including a decode stall and a pending EBREAK.
                if (bus.BRANCH_TAKEN) begin
                    pc_load      = 1'b1;
                    ifid_d.instr = NOP_INSTR;
                    ifid_d.valid = 1'b0;
                    if (target_misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALTED;
                    end
                end else if (state_q == ST_RUN) begin
                    if (pc_out_of_range) begin
                        ifid_d.instr = NOP_INSTR;
                        ifid_d.valid = 1'b0;
                        fault_d      = 1'b1;
                        state_d      = ST_HALTED;
                    end else if (!bus.STALL) begin
                        ifid_d  = '{pc: pc, instr: bus.INSTRUCTION, valid: 1'b1};
                        pc_inc  = 1'b1;
                        count_d = count_q + 32'd1;
                        if (bus.INSTRUCTION == EBREAK_INSTR) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
            end
            ST_HALTED: begin
                // Only draining of the last delivered entry remains.
                if (!bus.STALL) begin
                    ifid_d.valid = 1'b0;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    assign bus.INSTRUCTION_ADDRESS = word_addr;
    assign bus.PC_OUT              = ifid_p1.pc;
    assign bus.INSTR_OUT           = ifid_p1.instr;
    assign bus.VALID_OUT           = ifid_p1.valid;
    assign bus.HALTED              = (state_q == ST_HALTED);
    assign bus.FETCH_FAULT         = fault_q;
    assign bus.FETCH_COUNT         = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a spec-level reference model checked every cycle.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_unit_if #(.ADDR_W(10)) bus ();

    instr_fetch_unit #(.ADDR_W(10)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:1023];
    assign bus.INSTRUCTION = rom[bus.INSTRUCTION_ADDRESS];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the IF/ID boundary must hold, computed from the fetch rules.
    logic [31:0] m_pc, m_pc_out, m_instr, m_count;
    logic        m_valid, m_halted, m_fault, m_boot;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] n_pc, n_pc_out, n_instr, n_count;
        logic        n_valid, n_halted, n_fault;
        if (!rst_n) begin
            m_pc <= 32'd0; m_pc_out <= 32'd0; m_instr <= NOP; m_count <= 32'd0;
            m_valid <= 1'b0; m_halted <= 1'b0; m_fault <= 1'b0; m_boot <= 1'b1;
        end else begin
            n_pc = m_pc; n_pc_out = m_pc_out; n_instr = m_instr; n_count = m_count;
            n_valid = m_valid; n_halted = m_halted; n_fault = m_fault;
            if (m_halted) begin
                if (!bus.STALL) n_valid = 1'b0;
            end else if (bus.BRANCH_TAKEN) begin
                n_pc    = bus.BRANCH_TARGET & 32'hFFFF_FFFC;
                n_instr = NOP;
                n_valid = 1'b0;
                if (bus.BRANCH_TARGET % 4 != 0) begin
                    n_fault  = 1'b1;
                    n_halted = 1'b1;
                end
            end else if (m_boot) begin
                n_pc = m_pc;
            end else if (m_pc >= 32'd4096) begin
                n_instr  = NOP;
                n_valid  = 1'b0;
                n_fault  = 1'b1;
                n_halted = 1'b1;
            end else if (!bus.STALL) begin
                n_pc_out = m_pc;
                n_instr  = rom[m_pc / 4];
                n_valid  = 1'b1;
                n_pc     = m_pc + 32'd4;
                n_count  = m_count + 32'd1;
                if (n_instr == EBRK) n_halted = 1'b1;
            end
            m_pc <= n_pc; m_pc_out <= n_pc_out; m_instr <= n_instr; m_count <= n_count;
            m_valid <= n_valid; m_halted <= n_halted; m_fault <= n_fault; m_boot <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_addr",   32'(bus.INSTRUCTION_ADDRESS), (m_pc / 4) % 1024);
            chk("m_instr",  bus.INSTR_OUT,   m_instr);
            chk("m_valid",  32'(bus.VALID_OUT),   32'(m_valid));
            chk("m_halted", 32'(bus.HALTED),      32'(m_halted));
            chk("m_fault",  32'(bus.FETCH_FAULT), 32'(m_fault));
            chk("m_count",  bus.FETCH_COUNT, m_count);
            if (m_valid) chk("m_pc_out", bus.PC_OUT, m_pc_out);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.STALL = 1'b0; bus.BRANCH_TAKEN = 1'b0; bus.BRANCH_TARGET = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [31:0] exp_i [4];

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0100_0000 + 32'(i);
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        rom[1023] = 32'h0000_ABCD;
        exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33; exp_i[3] = 32'h44;
        bus.STALL = 1'b0; bus.BRANCH_TAKEN = 1'b0; bus.BRANCH_TARGET = 32'd0;

        // Reset values
        nxt();
        chk("rst_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd0);
        chk("rst_pcout", bus.PC_OUT, 32'd0);
        chk("rst_instr", bus.INSTR_OUT, NOP);
        chk("rst_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("rst_flags", {30'd0, bus.HALTED, bus.FETCH_FAULT}, 32'd0);
        chk("rst_count", bus.FETCH_COUNT, 32'd0);

        // Sequential fetch
        rst_n = 1'b1;
        nxt();
        chk("boot_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("boot_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("seq_instr", bus.INSTR_OUT, exp_i[i]);
            chk("seq_pcout", bus.PC_OUT, 32'(i * 4));
            chk("seq_valid", 32'(bus.VALID_OUT), 32'd1);
            chk("seq_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'(i + 1));
        end
        chk("seq_count", bus.FETCH_COUNT, 32'd4);

        // Stall, then redirect against stall, then misaligned redirect
        do_reset();
        repeat (3) nxt();
        chk("pre_stall_instr", bus.INSTR_OUT, 32'h22);
        bus.STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("stall_pcout", bus.PC_OUT, 32'd4);
            chk("stall_instr", bus.INSTR_OUT, 32'h22);
            chk("stall_count", bus.FETCH_COUNT, 32'd2);
            chk("stall_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd2);
        end
        bus.STALL = 1'b0;
        nxt();
        chk("resume_instr", bus.INSTR_OUT, 32'h33);
        chk("resume_pcout", bus.PC_OUT, 32'd8);
        bus.STALL = 1'b1; bus.BRANCH_TAKEN = 1'b1; bus.BRANCH_TARGET = 32'h40;
        nxt();
        chk("flush_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("flush_instr", bus.INSTR_OUT, 32'h13);
        chk("flush_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd16);
        bus.STALL = 1'b0; bus.BRANCH_TAKEN = 1'b0;
        nxt();
        chk("tgt_pcout", bus.PC_OUT, 32'h40);
        chk("tgt_instr", bus.INSTR_OUT, 32'h0100_0010);
        bus.BRANCH_TAKEN = 1'b1; bus.BRANCH_TARGET = 32'h42;
        nxt();
        bus.BRANCH_TAKEN = 1'b0;
        chk("mis_fault",  32'(bus.FETCH_FAULT), 32'd1);
        chk("mis_halted", 32'(bus.HALTED), 32'd1);
        chk("mis_valid",  32'(bus.VALID_OUT), 32'd0);
        chk("mis_addr",   32'(bus.INSTRUCTION_ADDRESS), 32'd16);
        repeat (2) nxt();
        chk("mis_frozen", 32'(bus.INSTRUCTION_ADDRESS), 32'd16);
        chk("mis_count",  bus.FETCH_COUNT, 32'd4);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd0);
        chk("arst_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("arst_flags", {30'd0, bus.HALTED, bus.FETCH_FAULT}, 32'd0);
        chk("arst_count", bus.FETCH_COUNT, 32'd0);
        chk("arst_instr", bus.INSTR_OUT, NOP);

        // EBREAK delivery, stall-held, then drained
        rom[3] = EBRK;
        do_reset();
        repeat (5) nxt();
        chk("ebk_instr",  bus.INSTR_OUT, EBRK);
        chk("ebk_valid",  32'(bus.VALID_OUT), 32'd1);
        chk("ebk_pcout",  bus.PC_OUT, 32'd12);
        chk("ebk_halted", 32'(bus.HALTED), 32'd1);
        bus.STALL = 1'b1;
        nxt();
        chk("ebk_hold_valid", 32'(bus.VALID_OUT), 32'd1);
        bus.STALL = 1'b0;
        nxt();
        chk("ebk_drain_valid", 32'(bus.VALID_OUT), 32'd0);
        repeat (3) nxt();
        chk("ebk_count",  bus.FETCH_COUNT, 32'd4);
        chk("ebk_addr",   32'(bus.INSTRUCTION_ADDRESS), 32'd4);
        rom[3] = 32'h44;

        // Redirect during BOOT to the last ROM word, then range fault
        do_reset();
        bus.BRANCH_TAKEN = 1'b1; bus.BRANCH_TARGET = 32'hFFC;
        nxt();
        bus.BRANCH_TAKEN = 1'b0;
        chk("end_addr",  32'(bus.INSTRUCTION_ADDRESS), 32'd1023);
        chk("end_valid", 32'(bus.VALID_OUT), 32'd0);
        nxt();
        chk("end_instr", bus.INSTR_OUT, 32'h0000_ABCD);
        chk("end_pcout", bus.PC_OUT, 32'hFFC);
        chk("end_valid2", 32'(bus.VALID_OUT), 32'd1);
        nxt();
        chk("oor_fault",  32'(bus.FETCH_FAULT), 32'd1);
        chk("oor_halted", 32'(bus.HALTED), 32'd1);
        chk("oor_valid",  32'(bus.VALID_OUT), 32'd0);
        chk("oor_addr",   32'(bus.INSTRUCTION_ADDRESS), 32'd0);
        chk("oor_count",  bus.FETCH_COUNT, 32'd1);
        repeat (2) nxt();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
